alu_exec: RTL and testbench

- 16-bit execute-stage ALU for the in-house 16-bit microprocessor; sits between the decoder/register-file read and writeback/data-memory.
- Takes two operands, the load data from data memory and a 6-bit decoded opcode.
- Produces a registered result, store data for data memory, an output-port value and carry/zero flags.

---
 rtl/alu_exec.sv | 195 +++++++++++++++++++
 tb/tb_alu_exec.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/alu_exec.sv
// ============================================================================
// Module  : alu_exec
// Brief   : 16-bit execute-stage ALU with registered result, store data,
//           output-port value and carry/zero flags. Optional multiply is
//           enabled by defining ALU_MUL_EN (opcode 011101).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_exec #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] data_in,
  input  logic [5:0]       op_dec,
  output logic [WIDTH-1:0] ans_ex,
  output logic [WIDTH-1:0] DM_data,
  output logic [WIDTH-1:0] data_out,
  output logic [1:0]       flag_ex
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [5:0] c_OP_ADD = 6'b000000;
  localparam logic [5:0] c_OP_ADI = 6'b000001;
  localparam logic [5:0] c_OP_SUB = 6'b000010;
  localparam logic [5:0] c_OP_SUI = 6'b000011;
  localparam logic [5:0] c_OP_AND = 6'b000100;
  localparam logic [5:0] c_OP_ANI = 6'b000101;
  localparam logic [5:0] c_OP_OR  = 6'b000110;
  localparam logic [5:0] c_OP_ORI = 6'b000111;
  localparam logic [5:0] c_OP_XOR = 6'b001000;
  localparam logic [5:0] c_OP_XRI = 6'b001001;
  localparam logic [5:0] c_OP_NOT = 6'b001010;
  localparam logic [5:0] c_OP_NTI = 6'b001011;
  localparam logic [5:0] c_OP_MOV = 6'b001100;
  localparam logic [5:0] c_OP_MVI = 6'b001101;
  localparam logic [5:0] c_OP_INC = 6'b001110;
  localparam logic [5:0] c_OP_DEC = 6'b001111;
  localparam logic [5:0] c_OP_LD  = 6'b010000;
  localparam logic [5:0] c_OP_ST  = 6'b010001;
  localparam logic [5:0] c_OP_SHL = 6'b010100;
  localparam logic [5:0] c_OP_SHR = 6'b010101;
  localparam logic [5:0] c_OP_SRA = 6'b010110;
  localparam logic [5:0] c_OP_ROL = 6'b010111;
  localparam logic [5:0] c_OP_ROR = 6'b011000;
  localparam logic [5:0] c_OP_OUT = 6'b011001;
  localparam logic [5:0] c_OP_CMP = 6'b011010;
  localparam logic [5:0] c_OP_NEG = 6'b011011;
  localparam logic [5:0] c_OP_ADC = 6'b011100;
`ifdef ALU_MUL_EN
  localparam logic [5:0] c_OP_MUL = 6'b011101;
`endif

  localparam logic [SHW:0]   c_WIDTH_AMT = (SHW+1)'(WIDTH);
  localparam logic [WIDTH-1:0] c_ONE     = WIDTH'(1);
  localparam logic [WIDTH-1:0] c_ZERO    = '0;

  logic [WIDTH-1:0] r_ans;
  logic [WIDTH-1:0] r_dm;
  logic [WIDTH-1:0] r_out;
  logic [1:0]       r_flag;

  logic [SHW-1:0]   w_shamt;
  logic [SHW:0]     w_ramt;
  logic [WIDTH-1:0] w_add_b;
  logic             w_cin;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_sub_x;
  logic [WIDTH-1:0] w_sub_y;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH:0]   w_shl_ext;
  logic [WIDTH:0]   w_shr_ext;
  logic signed [WIDTH:0] w_sra_ext;
  logic [WIDTH-1:0] w_rol;
  logic [WIDTH-1:0] w_ror;
  logic             w_amt_nz;
`ifdef ALU_MUL_EN
  logic [2*WIDTH-1:0] w_prod;
`endif

  logic [WIDTH-1:0] w_res;
  logic             w_carry;
  logic             w_wr_ans;
  logic             w_wr_flag;
  logic             w_wr_dm;
  logic             w_wr_out;

  assign w_shamt  = B[SHW-1:0];
  assign w_ramt   = c_WIDTH_AMT - {1'b0, w_shamt};
  assign w_amt_nz = (w_shamt != '0);

  // One adder and one subtractor are shared by every opcode using add/sub rules
  assign w_add_b = (op_dec == c_OP_INC) ? c_ONE : B;
  assign w_cin   = (op_dec == c_OP_ADC) ? r_flag[1] : 1'b0;
  assign w_sum   = {1'b0, A} + {1'b0, w_add_b} + {{WIDTH{1'b0}}, w_cin};

  assign w_sub_x = (op_dec == c_OP_NEG) ? c_ZERO : A;
  assign w_sub_y = (op_dec == c_OP_NEG) ? A : ((op_dec == c_OP_DEC) ? c_ONE : B);
  assign w_diff  = {1'b0, w_sub_x} - {1'b0, w_sub_y};

  // The extra bit of each extended shift catches the last bit shifted out
  assign w_shl_ext = {1'b0, A} << w_shamt;
  assign w_shr_ext = {A, 1'b0} >> w_shamt;
  assign w_sra_ext = $signed({A, 1'b0}) >>> w_shamt;
  assign w_rol     = (A << w_shamt) | (A >> w_ramt);
  assign w_ror     = (A >> w_shamt) | (A << w_ramt);

`ifdef ALU_MUL_EN
  assign w_prod = {{WIDTH{1'b0}}, A} * {{WIDTH{1'b0}}, B};
`endif

  always_comb begin
    w_res     = r_ans;
    w_carry   = 1'b0;
    w_wr_ans  = 1'b0;
    w_wr_flag = 1'b0;
    w_wr_dm   = 1'b0;
    w_wr_out  = 1'b0;
    case (op_dec)
      c_OP_ADD, c_OP_ADI, c_OP_INC, c_OP_ADC: begin
        w_res = w_sum[WIDTH-1:0]; w_carry = w_sum[WIDTH];
        w_wr_ans = 1'b1; w_wr_flag = 1'b1;
      end
      c_OP_SUB, c_OP_SUI, c_OP_DEC, c_OP_NEG: begin
        w_res = w_diff[WIDTH-1:0]; w_carry = w_diff[WIDTH];
        w_wr_ans = 1'b1; w_wr_flag = 1'b1;
      end
      c_OP_CMP: begin
        w_res = w_diff[WIDTH-1:0]; w_carry = w_diff[WIDTH];
        w_wr_flag = 1'b1;
      end
      c_OP_AND, c_OP_ANI: begin w_res = A & B; w_wr_ans = 1'b1; w_wr_flag = 1'b1; end
      c_OP_OR,  c_OP_ORI: begin w_res = A | B; w_wr_ans = 1'b1; w_wr_flag = 1'b1; end
      c_OP_XOR, c_OP_XRI: begin w_res = A ^ B; w_wr_ans = 1'b1; w_wr_flag = 1'b1; end
      c_OP_NOT, c_OP_NTI: begin w_res = ~B;    w_wr_ans = 1'b1; w_wr_flag = 1'b1; end
      c_OP_MOV, c_OP_MVI: begin w_res = B;     w_wr_ans = 1'b1; w_wr_flag = 1'b1; end
      c_OP_LD:  begin w_res = data_in; w_wr_ans = 1'b1; w_wr_flag = 1'b1; end
      c_OP_ST:  begin w_res = B; w_wr_ans = 1'b1; w_wr_dm = 1'b1; end
      c_OP_OUT: w_wr_out = 1'b1;
      c_OP_SHL: begin
        w_res = w_shl_ext[WIDTH-1:0]; w_carry = w_shl_ext[WIDTH];
        w_wr_ans = 1'b1; w_wr_flag = 1'b1;
      end
      c_OP_SHR: begin
        w_res = w_shr_ext[WIDTH:1]; w_carry = w_shr_ext[0];
        w_wr_ans = 1'b1; w_wr_flag = 1'b1;
      end
      c_OP_SRA: begin
        w_res = w_sra_ext[WIDTH:1]; w_carry = w_sra_ext[0];
        w_wr_ans = 1'b1; w_wr_flag = 1'b1;
      end
      c_OP_ROL: begin
        w_res = w_rol; w_carry = w_amt_nz & w_rol[0];
        w_wr_ans = 1'b1; w_wr_flag = 1'b1;
      end
      c_OP_ROR: begin
        w_res = w_ror; w_carry = w_amt_nz & w_ror[WIDTH-1];
        w_wr_ans = 1'b1; w_wr_flag = 1'b1;
      end
`ifdef ALU_MUL_EN
      c_OP_MUL: begin
        w_res = w_prod[WIDTH-1:0]; w_carry = (w_prod[2*WIDTH-1:WIDTH] != '0);
        w_wr_ans = 1'b1; w_wr_flag = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ans  <= '0;
      r_dm   <= '0;
      r_out  <= '0;
      r_flag <= '0;
    end else begin
      if (w_wr_ans)  r_ans  <= w_res;
      if (w_wr_flag) r_flag <= {w_carry, (w_res == '0)};
      if (w_wr_dm)   r_dm   <= A;
      if (w_wr_out)  r_out  <= A;
    end
  end

  assign ans_ex   = r_ans;
  assign DM_data  = r_dm;
  assign data_out = r_out;
  assign flag_ex  = r_flag;

endmodule

`default_nettype wire

// File: tb/tb_alu_exec.sv
// ============================================================================
// Module  : tb_alu_exec
// Brief   : Self-checking bench for alu_exec: directed cases plus randomized
//           ops checked against an arithmetic reference model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_exec;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] A, B, data_in;
  logic [5:0]  op_dec;
  logic [15:0] ans_ex, DM_data, data_out;
  logic [1:0]  flag_ex;

  int errors = 0;
  int checks = 0;

  logic [15:0] m_ans, m_dm, m_out;
  logic [1:0]  m_flag;

  alu_exec #(.WIDTH(16)) dut (
    .clk(clk), .reset(reset), .A(A), .B(B), .data_in(data_in), .op_dec(op_dec),
    .ans_ex(ans_ex), .DM_data(DM_data), .data_out(data_out), .flag_ex(flag_ex)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %h expected %h", tag, $time, obs, exp);
    end
  endtask

  task automatic set_res(input logic [15:0] r, input logic c);
    m_ans  = r;
    m_flag = {c, (r == 16'h0000)};
  endtask

  // Reference model: each op derived from the arithmetic rules directly
  task automatic model(input logic [5:0] op, input logic [15:0] a, b, d);
    int s;
    int n;
    logic [15:0] r;
    logic c;
    n = int'(b[3:0]);
    r = a;
    c = 1'b0;
    case (op)
      6'd0, 6'd1: begin s = int'(a) + int'(b); set_res(s[15:0], s > 65535); end
      6'd28: begin s = int'(a) + int'(b) + int'(m_flag[1]); set_res(s[15:0], s > 65535); end
      6'd14: begin s = int'(a) + 1; set_res(s[15:0], s > 65535); end
      6'd2, 6'd3: set_res(a - b, a < b);
      6'd15: set_res(a - 16'd1, a < 16'd1);
      6'd27: set_res(16'd0 - a, a != 16'd0);
      6'd26: m_flag = {a < b, a == b};
      6'd4, 6'd5: set_res(a & b, 1'b0);
      6'd6, 6'd7: set_res(a | b, 1'b0);
      6'd8, 6'd9: set_res(a ^ b, 1'b0);
      6'd10, 6'd11: set_res(~b, 1'b0);
      6'd12, 6'd13: set_res(b, 1'b0);
      6'd16: set_res(d, 1'b0);
      6'd17: begin m_dm = a; m_ans = b; end
      6'd25: m_out = a;
      6'd20: begin for (int i = 0; i < n; i++) begin c = r[15]; r = r << 1; end set_res(r, c); end
      6'd21: begin for (int i = 0; i < n; i++) begin c = r[0]; r = r >> 1; end set_res(r, c); end
      6'd22: begin for (int i = 0; i < n; i++) begin c = r[0]; r = {r[15], r[15:1]}; end set_res(r, c); end
      6'd23: begin for (int i = 0; i < n; i++) r = {r[14:0], r[15]}; set_res(r, (n > 0) && r[0]); end
      6'd24: begin for (int i = 0; i < n; i++) r = {r[0], r[15:1]}; set_res(r, (n > 0) && r[15]); end
`ifdef ALU_MUL_EN
      6'd29: begin
        longint p;
        p = longint'(a) * longint'(b);
        set_res(p[15:0], p[31:16] != 16'h0000);
      end
`endif
      default: ;
    endcase
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".ans"}, {16'h0, ans_ex}, {16'h0, m_ans});
    chk({tag, ".dm"},  {16'h0, DM_data}, {16'h0, m_dm});
    chk({tag, ".out"}, {16'h0, data_out}, {16'h0, m_out});
    chk({tag, ".flg"}, {30'h0, flag_ex}, {30'h0, m_flag});
  endtask

  task automatic model_clear();
    m_ans = '0; m_dm = '0; m_out = '0; m_flag = '0;
  endtask

  task automatic step(input logic [5:0] op, input logic [15:0] a, b, d, input string tag);
    A = a; B = b; data_in = d; op_dec = op;
    @(posedge clk);
    #1;
    model(op, a, b, d);
    check_all(tag);
  endtask

  function automatic logic [15:0] rnd16();
    case ($urandom_range(0, 7))
      0: return 16'h0000;
      1: return 16'hFFFF;
      2: return 16'h8000;
      3: return 16'($urandom_range(0, 20));
      default: return 16'($urandom);
    endcase
  endfunction

  logic [5:0] ops [27] = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7, 6'd8,
                           6'd9, 6'd10, 6'd11, 6'd12, 6'd13, 6'd14, 6'd15, 6'd16,
                           6'd17, 6'd20, 6'd21, 6'd22, 6'd23, 6'd24, 6'd25, 6'd26,
                           6'd27, 6'd28};

  initial begin
    reset = 1'b1; A = 16'h1234; B = 16'h5678; data_in = 16'h0; op_dec = 6'd0;
    model_clear();
    #1 reset = 1'b0;
    #2;
    check_all("rst_async");
    @(posedge clk); @(posedge clk); #1;
    check_all("rst_hold");
    reset = 1'b1;
    step(6'd0, 16'h1234, 16'h5678, 16'h0, "rst_first");
    chk("rst_first_val", {16'h0, ans_ex}, 32'h68AC);

    step(6'd0,  16'h4000, 16'hC000, 16'h0, "add");
    chk("add_ans", {16'h0, ans_ex}, 32'h0000); chk("add_flg", {30'h0, flag_ex}, 32'd3);
    step(6'd2,  16'h4000, 16'hC000, 16'h0, "sub");
    chk("sub_ans", {16'h0, ans_ex}, 32'h8000); chk("sub_flg", {30'h0, flag_ex}, 32'd2);
    step(6'd14, 16'h4000, 16'hC000, 16'h0, "inc");
    chk("inc_ans", {16'h0, ans_ex}, 32'h4001); chk("inc_flg", {30'h0, flag_ex}, 32'd0);
    step(6'd4,  16'h4000, 16'hC000, 16'h0, "and"); chk("and_ans", {16'h0, ans_ex}, 32'h4000);
    step(6'd6,  16'h4000, 16'hC000, 16'h0, "or");  chk("or_ans",  {16'h0, ans_ex}, 32'hC000);
    step(6'd8,  16'h4000, 16'hC000, 16'h0, "xor"); chk("xor_ans", {16'h0, ans_ex}, 32'h8000);
    step(6'd10, 16'h4000, 16'hC000, 16'h0, "not"); chk("not_ans", {16'h0, ans_ex}, 32'h3FFF);
    chk("not_flg", {30'h0, flag_ex}, 32'd0);
    step(6'd16, 16'h4000, 16'hC000, 16'h0008, "ld"); chk("ld_ans", {16'h0, ans_ex}, 32'h0008);
    step(6'd17, 16'h4000, 16'hC000, 16'h0008, "st");
    chk("st_dm", {16'h0, DM_data}, 32'h4000); chk("st_ans", {16'h0, ans_ex}, 32'hC000);
    step(6'd25, 16'h4000, 16'hC000, 16'h0008, "out");
    chk("out_val", {16'h0, data_out}, 32'h4000); chk("out_ans", {16'h0, ans_ex}, 32'hC000);
    step(6'd20, 16'hC000, 16'h0001, 16'h0, "shl");
    chk("shl_ans", {16'h0, ans_ex}, 32'h8000); chk("shl_c", {31'h0, flag_ex[1]}, 32'd1);
    step(6'd21, 16'hC000, 16'h0001, 16'h0, "shr");
    chk("shr_ans", {16'h0, ans_ex}, 32'h6000); chk("shr_c", {31'h0, flag_ex[1]}, 32'd0);
    step(6'd22, 16'hC000, 16'h0001, 16'h0, "sra"); chk("sra_ans", {16'h0, ans_ex}, 32'hE000);
    step(6'd23, 16'hC000, 16'h0001, 16'h0, "rol");
    chk("rol_ans", {16'h0, ans_ex}, 32'h8001); chk("rol_c", {31'h0, flag_ex[1]}, 32'd1);
    step(6'd24, 16'hC000, 16'h0001, 16'h0, "ror");
    chk("ror_ans", {16'h0, ans_ex}, 32'h6000); chk("ror_c", {31'h0, flag_ex[1]}, 32'd0);
    step(6'd20, 16'hC000, 16'h0000, 16'h0, "shl0");
    chk("shl0_c", {31'h0, flag_ex[1]}, 32'd0);
    step(6'd26, 16'h1234, 16'h1234, 16'h0, "cmp");
    chk("cmp_flg", {30'h0, flag_ex}, 32'd1); chk("cmp_ans", {16'h0, ans_ex}, 32'hC000);
    step(6'd30, 16'hFFFF, 16'h0001, 16'h1, "nop1");
    step(6'd30, 16'h0001, 16'hFFFF, 16'h1, "nop2");
    step(6'd31, 16'hFFFF, 16'h0001, 16'h1, "hlt1");
    step(6'd31, 16'h0001, 16'hFFFF, 16'h1, "hlt2");
    step(6'd63, 16'hFFFF, 16'h0001, 16'h1, "unl1");
    step(6'd63, 16'h0001, 16'hFFFF, 16'h1, "unl2");
    chk("hold_ans", {16'h0, ans_ex}, 32'hC000); chk("hold_flg", {30'h0, flag_ex}, 32'd1);
    step(6'd0,  16'h4000, 16'hC000, 16'h0, "add_c");
    step(6'd28, 16'h0001, 16'h0002, 16'h0, "adc");
    chk("adc_ans", {16'h0, ans_ex}, 32'h0004);

    for (int i = 0; i < 400; i++) begin
      logic [5:0] op;
      op = ($urandom_range(0, 7) == 0) ? 6'($urandom) : ops[$urandom_range(0, 26)];
      step(op, rnd16(), rnd16(), rnd16(), "rnd");
    end

    // Asynchronous reset between clock edges, then normal execution resumes
    #2 reset = 1'b0;
    #1 model_clear();
    check_all("rst_mid");
    @(posedge clk); #1 reset = 1'b1;
    step(6'd2, 16'h0005, 16'h0007, 16'h0, "rst_resume");
    chk("rst_resume_ans", {16'h0, ans_ex}, 32'hFFFE);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
